test_ram_arbiter: RTL

- Shares the single-port block test RAM between two requesters: m0 (instruction fetch) and m1 (data access).
- Each requester has a level request / one-cycle ack handshake. The arbiter drives the RAM's req_rdwr/we/addr/data_in and waits for the RAM's data_ready before it returns read data.
- Round-robin fairness; one outstanding RAM transaction at a time.
- Sits between the 65c816 core bus interface and the test RAM wrapper.

---
 rtl/test_ram_arbiter_pkg.sv | 17 +
 rtl/test_ram_arbiter_if.sv | 17 +
 rtl/test_ram_arbiter_rr_arbiter_2.sv | 13 +
 rtl/test_ram_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/test_ram_arbiter_pkg.sv
// Shared test-RAM widths, arbiter FSM state encodings and default timeout
// for the test RAM arbiter.
package test_ram_arbiter_pkg;

  localparam int TRA_ADDR_MSB       = 15;
  localparam int TRA_DATA_MSB       = 7;
  localparam int TRA_ADDR_W         = TRA_ADDR_MSB + 1;
  localparam int TRA_DATA_W         = TRA_DATA_MSB + 1;
  localparam int TRA_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    TRA_ST_IDLE = 2'd0,
    TRA_ST_BUSY = 2'd1,
    TRA_ST_DONE = 2'd2
  } tra_state_t;

endpackage

// File: rtl/test_ram_arbiter_if.sv
// Requester-side level request / one-cycle ack handshake into the test RAM arbiter.
interface test_ram_arbiter_if
  import test_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = TRA_ADDR_W,
  parameter int DATA_W = TRA_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/test_ram_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick; on a tie the side that did not win last goes.
module rr_arbiter_2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic winner,
  output logic valid
);
  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last_grant : req1;
  end
endmodule

// File: rtl/test_ram_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port test RAM.
// Optional BUSY timeout abort enabled by defining TR_ARB_TIMEOUT_EN.
module test_ram_arbiter
  import test_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = TRA_ADDR_W,
  parameter int DATA_W         = TRA_DATA_W,
  parameter int TIMEOUT_CYCLES = TRA_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  test_ram_arbiter_if.slave m0,
  test_ram_arbiter_if.slave m1,
  output logic              ram_req_rdwr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_data_ready,
  output logic              grant,
  output logic              busy,
  output logic              err
);

  if (ADDR_W != TRA_ADDR_MSB + 1) begin : g_bad_addr_w
    $error("ADDR_W must match the shared test-RAM address width");
  end
  if (DATA_W != TRA_DATA_MSB + 1) begin : g_bad_data_w
    $error("DATA_W must match the shared test-RAM data width");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  tra_state_t state;
  logic       last_grant;
  logic       pick;
  logic       pick_valid;

  rr_arbiter_2 u_rr (
    .req0       (m0.req),
    .req1       (m1.req),
    .last_grant (last_grant),
    .winner     (pick),
    .valid      (pick_valid)
  );

`ifdef TR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= TRA_ST_IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      busy         <= 1'b0;
      ram_req_rdwr <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      m0.ack       <= 1'b0;
      m1.ack       <= 1'b0;
      m0.rdata     <= '0;
      m1.rdata     <= '0;
`ifdef TR_ARB_TIMEOUT_EN
      err          <= 1'b0;
      busy_cnt     <= '0;
`endif
    end else begin
      case (state)
        TRA_ST_IDLE: begin
          if (pick_valid) begin
            grant        <= pick;
            ram_req_rdwr <= 1'b1;
            ram_we       <= pick ? m1.we    : m0.we;
            ram_addr     <= pick ? m1.addr  : m0.addr;
            ram_data_in  <= pick ? m1.wdata : m0.wdata;
            busy         <= 1'b1;
            state        <= TRA_ST_BUSY;
`ifdef TR_ARB_TIMEOUT_EN
            busy_cnt     <= '0;
`endif
          end
        end

        TRA_ST_BUSY: begin
          if (ram_data_ready) begin
            if (grant) begin
              m1.rdata <= ram_data_out;
              m1.ack   <= 1'b1;
            end else begin
              m0.rdata <= ram_data_out;
              m0.ack   <= 1'b1;
            end
            ram_req_rdwr <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_in  <= '0;
            last_grant   <= grant;
            state        <= TRA_ST_DONE;
          end
`ifdef TR_ARB_TIMEOUT_EN
          // Abort path: ack with zero data so the requester never stalls forever.
          else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (grant) begin
              m1.rdata <= '0;
              m1.ack   <= 1'b1;
            end else begin
              m0.rdata <= '0;
              m0.ack   <= 1'b1;
            end
            err          <= 1'b1;
            ram_req_rdwr <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_in  <= '0;
            last_grant   <= grant;
            state        <= TRA_ST_DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end

        TRA_ST_DONE: begin
          // RAM ready is still high from this request here, so it is ignored.
          m0.ack <= 1'b0;
          m1.ack <= 1'b0;
          busy   <= 1'b0;
          state  <= TRA_ST_IDLE;
`ifdef TR_ARB_TIMEOUT_EN
          err    <= 1'b0;
`endif
        end

        default: state <= TRA_ST_IDLE;
      endcase
    end
  end

endmodule
